bus_initiator: RTL
==================

Name: bus_initiator

Overview:
- Hardware bus master for the 16-bit addr/data/rw/valid register bus used by the debug cores (e.g. logic_analyzer).
- Accepts one read/write command at a time over a valid/ready handshake and drives it onto the core chain as a single-cycle request.
- Waits for the matching return beat from the end of the chain, then presents the read data, or a timeout, on a response handshake.
- This is the synthesizable counterpart of bench-side read/write tasks; it sits between a host-interface command decoder and the first core in the chain.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait in WAIT for a matching return before reporting a timeout. Must be ≥1. Counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  initiator can accept a command
- cmd_addr_i  in  16  register address
- cmd_data_i  in  16  write data (ignored for reads)
- cmd_rw_i  in  1  1 = write, 0 = read
- addr_o  out  16  bus request address to chain
- data_o  out  16  bus request data to chain
- rw_o  out  1  bus request direction
- valid_o  out  1  bus request strobe, one cycle per transaction
- addr_i  in  16  return address from chain end
- data_i  in  16  return data from chain end
- rw_i  in  1  return direction
- valid_i  in  1  return strobe
- resp_valid_o  out  1  response present
- resp_ready_i  in  1  consumer takes response
- resp_data_o  out  16  read data (write: echoed write data)
- resp_timeout_o  out  1  transaction timed out
- resp_mismatch_o  out  1  readback mismatch (optional feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except cmd_ready_o=1. Asserting reset mid-transaction drops valid_o and resp_valid_o immediately and abandons the transaction. No response is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On cmd_valid_i&&cmd_ready_o, register addr/data/rw into addr_o/data_o/rw_o and go to ISSUE.
- ISSUE:
  - valid_o=1 for exactly this one cycle.
  - Then go to WAIT with the timeout counter cleared to 0.
  - Any valid_i during ISSUE is ignored; the chain has ≥1 cycle latency.
- WAIT:
  - Match condition: valid_i && addr_i==addr_o && rw_i==rw_o.
  - On a match, capture data_i into resp_data_o, set resp_timeout_o=0, and go to RESP.
  - Non-matching valid_i beats are ignored.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no match, set resp_timeout_o=1 and resp_data_o=0, then go to RESP.
  - A match in the same cycle as the counter reaching the limit counts as success, not a timeout.
- RESP:
  - resp_valid_o=1; resp_* fields are held stable until the response is taken.
  - On resp_ready_i, go to IDLE; cmd_ready_o returns to 1 the following cycle. There is no command/response overlap.
- addr_o/data_o/rw_o hold their last issued values while valid_o=0.
- Latency: command accept to valid_o is 1 cycle. valid_o to earliest resp_valid_o is chain latency + 1 cycle.

Optional Feature:
- Macro: BUS_INITIATOR_READBACK_VERIFY_EN.
- Defined:
  - After a successful write match, automatically re-enter ISSUE with rw_o=0 at the same address.
  - Wait for the read return, then compare data_i to the written data.
  - resp_mismatch_o=1 if they differ; resp_data_o = read-back value.
  - Only one response is produced per write command.
  - A timeout in either phase gives resp_timeout_o=1, resp_mismatch_o=0.
  - Reads are unaffected.
- Undefined: resp_mismatch_o is tied 0; the port remains present.

Test Plan:
- Write (addr 0x0003, data 0x0001) with a 3-cycle loopback responder:
  - valid_o pulses exactly 1 cycle with rw_o=1.
  - resp_valid_o asserts 4 cycles after that pulse.
  - resp_timeout_o=0, resp_data_o=0x0001.
- Read addr 0x0008, responder returns 0x00A5: resp_data_o=0x00A5; cmd_ready_o=0 from accept until the response is taken.
- Responder silent, TIMEOUT_CYCLES=8: resp_timeout_o=1 after 8 WAIT cycles, resp_data_o=0. A late return arriving after the timeout is ignored in IDLE.
- Stray return beat (addr 0x0004) during WAIT for addr 0x0005, then the correct beat: only the 0x0005 data is reported.
- resp_ready_i held low for 10 cycles: resp_* stays stable and a new cmd_valid_i is not accepted. rst_n pulsed low during WAIT: all outputs return to reset values asynchronously, with no response.
- With BUS_INITIATOR_READBACK_VERIFY_EN, write 0x0007 to a register whose readback masks to 3 bits:
  - Expect two valid_o pulses (rw 1 then 0).
  - Response: resp_mismatch_o=0, resp_data_o=0x0007.
  - Writing 0x000F gives resp_mismatch_o=1, resp_data_o=0x0007.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding master for the 16-bit addr/data/rw/valid debug-core bus.
// Takes one command, issues it as a one-cycle request, waits for the matching return beat
// (or a timeout) and holds the result on a response handshake.
// Optional feature macro: BUS_INITIATOR_READBACK_VERIFY_EN re-reads every write and flags
// a readback mismatch on resp_mismatch_o; without it that port is tied low.
module bus_initiator #(
    parameter  int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned BUS_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // command handshake
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [BUS_W-1:0] cmd_addr_i,
    input  logic [BUS_W-1:0] cmd_data_i,
    input  logic             cmd_rw_i,
    // request into the core chain
    output logic [BUS_W-1:0] addr_o,
    output logic [BUS_W-1:0] data_o,
    output logic             rw_o,
    output logic             valid_o,
    // return from the end of the chain
    input  logic [BUS_W-1:0] addr_i,
    input  logic [BUS_W-1:0] data_i,
    input  logic             rw_i,
    input  logic             valid_i,
    // response handshake
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [BUS_W-1:0] resp_data_o,
    output logic             resp_timeout_o,
    output logic             resp_mismatch_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BUS_W-1:0] addr_d, data_d, resp_data_d;
    logic             rw_d, valid_d, cmd_ready_d;
    logic             resp_valid_d, resp_timeout_d;
    logic             match_c;

`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
    logic verify_q, verify_d;
    logic mismatch_q, mismatch_d;
    assign resp_mismatch_o = mismatch_q;
`else
    assign resp_mismatch_o = 1'b0;
`endif

    // A return beat belongs to us only if it echoes the outstanding address and direction
    assign match_c = valid_i && (addr_i == addr_o) && (rw_i == rw_o);

    // Next-state and next-output decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_o;
        data_d         = data_o;
        rw_d           = rw_o;
        valid_d        = 1'b0;
        cmd_ready_d    = 1'b0;
        resp_valid_d   = 1'b0;
        resp_data_d    = resp_data_o;
        resp_timeout_d = resp_timeout_o;
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
        verify_d       = verify_q;
        mismatch_d     = mismatch_q;
`endif
        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_o) begin
                    addr_d      = cmd_addr_i;
                    data_d      = cmd_data_i;
                    rw_d        = cmd_rw_i;
                    valid_d     = 1'b1;
                    cmd_ready_d = 1'b0;
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
                    verify_d    = 1'b0;
`endif
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (match_c) begin
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
                    if (rw_o) begin
                        // Write landed: read the same address back before answering
                        rw_d     = 1'b0;
                        valid_d  = 1'b1;
                        verify_d = 1'b1;
                        state_d  = ISSUE;
                    end else begin
                        resp_data_d    = data_i;
                        resp_timeout_d = 1'b0;
                        mismatch_d     = verify_q && (data_i != data_o);
                        verify_d       = 1'b0;
                        resp_valid_d   = 1'b1;
                        state_d        = RESP;
                    end
`else
                    resp_data_d    = data_i;
                    resp_timeout_d = 1'b0;
                    resp_valid_d   = 1'b1;
                    state_d        = RESP;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    resp_data_d    = '0;
                    resp_timeout_d = 1'b1;
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
                    mismatch_d     = 1'b0;
                    verify_d       = 1'b0;
`endif
                    resp_valid_d   = 1'b1;
                    state_d        = RESP;
                end
            end
            RESP: begin
                resp_valid_d = 1'b1;
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    cmd_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_o         <= '0;
            data_o         <= '0;
            rw_o           <= 1'b0;
            valid_o        <= 1'b0;
            cmd_ready_o    <= 1'b1;
            resp_valid_o   <= 1'b0;
            resp_data_o    <= '0;
            resp_timeout_o <= 1'b0;
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
            verify_q       <= 1'b0;
            mismatch_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_o         <= addr_d;
            data_o         <= data_d;
            rw_o           <= rw_d;
            valid_o        <= valid_d;
            cmd_ready_o    <= cmd_ready_d;
            resp_valid_o   <= resp_valid_d;
            resp_data_o    <= resp_data_d;
            resp_timeout_o <= resp_timeout_d;
`ifdef BUS_INITIATOR_READBACK_VERIFY_EN
            verify_q       <= verify_d;
            mismatch_q     <= mismatch_d;
`endif
        end
    end

endmodule
